mcycle_seq: RTL

// - Iterative multi-cycle MUL/DIV unit with its sequencing FSM; sits beside the ALU in Execute.
// - Driven by the Decoder's Start / MCycleOp outputs; raises Busy so the hazard logic stalls the pipeline.
// - Shift-add multiply and restoring divide, one bit per cycle; signed ops run on magnitudes with a sign fix-up at the end.

---
 rtl/mcycle_pkg.sv | 25 ++
 rtl/mcycle_step.sv | 33 +++
 rtl/mcycle_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mcycle_pkg.sv
// Shared encodings and helpers for the iterative MUL/DIV unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    MCYCLE_SMUL = 2'b00,
    MCYCLE_UMUL = 2'b01,
    MCYCLE_SDIV = 2'b10,
    MCYCLE_UDIV = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COMPUTING = 2'b01,
    ST_DONE      = 2'b10
  } mcycle_state_e;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mcycle_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module mcycle_step
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic [1:0]         i_op,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_s;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
            + {1'b0, (i_acc[0] ? i_operand : {WIDTH{1'b0}})};
    w_rem_s = i_acc[2*WIDTH-1:WIDTH-1];
    w_trial = w_rem_s - {1'b0, i_operand};
    o_qbit  = 1'b0;
    o_acc   = {w_sum, i_acc[WIDTH-1:1]};
    // Quotient LSB is left clear here; the sequencer merges o_qbit into it.
    if (is_div(i_op)) begin
      o_qbit = ~w_trial[WIDTH];
      o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_rem_s[WIDTH-1:0]),
                i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle MUL/DIV sequencer: latches magnitudes on Start, iterates WIDTH times,
// applies the sign fix-up as results are registered, then pulses Done.
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  mcycle_state_e      r_state;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic               r_sign1;
  logic               r_sign2;
  logic               r_div0;
  logic [WIDTH-1:0]   r_result1;
  logic [WIDTH-1:0]   r_result2;
  logic               r_done;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [2*WIDTH-1:0] w_step_acc;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_neg;
  logic [WIDTH-1:0]   w_res1;
  logic [WIDTH-1:0]   w_res2;

  assign w_mag1 = (is_signed(MCycleOp) && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign w_mag2 = (is_signed(MCycleOp) && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

  mcycle_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_op      (r_op),
    .o_acc     (w_step_acc),
    .o_qbit    (w_qbit)
  );

  assign w_acc_next = {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_qbit};

  // Sign fix-up on the final iteration's output; divide-by-zero overrides the quotient.
  always_comb begin
    w_neg  = -w_acc_next;
    w_res1 = w_acc_next[WIDTH-1:0];
    w_res2 = w_acc_next[2*WIDTH-1:WIDTH];
    if (is_div(r_op)) begin
      if (r_div0) begin
        w_res1 = {WIDTH{1'b1}};
      end else if (r_sign1 ^ r_sign2) begin
        w_res1 = -w_acc_next[WIDTH-1:0];
      end
      if (r_sign1) begin
        w_res2 = -w_acc_next[2*WIDTH-1:WIDTH];
      end
    end else if (r_sign1 ^ r_sign2) begin
      w_res1 = w_neg[WIDTH-1:0];
      w_res2 = w_neg[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_div0    <= 1'b0;
      r_result1 <= '0;
      r_result2 <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_op      <= MCycleOp;
            r_sign1   <= is_signed(MCycleOp) & Operand1[WIDTH-1];
            r_sign2   <= is_signed(MCycleOp) & Operand2[WIDTH-1];
            r_div0    <= (Operand2 == '0);
            r_count   <= '0;
            r_acc     <= is_div(MCycleOp) ? {{WIDTH{1'b0}}, w_mag1} : {{WIDTH{1'b0}}, w_mag2};
            r_operand <= is_div(MCycleOp) ? w_mag2 : w_mag1;
            r_state   <= ST_COMPUTING;
          end
        end
        ST_COMPUTING: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_result1 <= w_res1;
            r_result2 <= w_res2;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy    = ~RESET & (((r_state == ST_IDLE) & Start) | (r_state == ST_COMPUTING));
  assign Done    = r_done;
  assign Result1 = r_result1;
  assign Result2 = r_result2;

endmodule
